ctrl_pipe: RTL and testbench
============================

Name: ctrl_pipe

Overview:
- Parametrised successor to the single-cycle control ROM.
- Decodes opcode/funct3/funct7 into an rv32i_control_word and carries it through STAGES registered pipeline slots, each with a valid bit.
- Supports stall, partial flush, and a multi-cycle hold for M-extension mul/div ops.
- Sits between fetch/decode and the EX/MEM/WB datapath; datapath stages read their control from the matching slot.

Parameters:
- STAGES, 4, number of control-word pipeline slots (slot 0 = EX); legal range 2..8.
- FLUSH_DEPTH, 2, slots 0..FLUSH_DEPTH-1 cleared by flush_i; must be 1..STAGES.
- MULDIV_EN, 1, 1 = recognise op_reg with funct7=7'b0000001 as multi-cycle; 0 = treat as ordinary ALU op.
- MULDIV_CYCLES, 32, total cycles slot 0 is held for a mul/div op; must be >= 2.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, decode input valid.
- in_ready, out, 1, block accepts input this cycle.
- opcode, in, 7 (rv32i_opcode), instruction opcode.
- funct3, in, 3, instruction funct3.
- funct7, in, 7, instruction funct7.
- stall_i, in, 1, global back-pressure from the datapath.
- flush_i, in, 1, branch/jump redirect; squashes younger slots.
- slot_ctrl, out, STAGES x $bits(rv32i_control_word), control word per slot.
- slot_valid, out, STAGES, valid per slot.
- illegal_o, out, 1, slot 0 holds an instruction with an unknown opcode.
- md_busy, out, 1, mul/div hold in progress.

Behaviour:
- Reset (rst_n=0, async): all slot_valid=0, all slot_ctrl=0, illegal_o=0, md counter=0, md_busy=0. Outputs take these values immediately on assertion; normal operation resumes from the first clk edge after release.
- Decode (combinational): default word is all zeros with ctrl.opcode=opcode, then a case on opcode. An unknown opcode gives word=0 and an internal illegal flag.
- Hold signal: md_hold = (md counter != 0).
- in_ready = !stall_i && !md_hold && !flush_i.
- Accept: in_valid && in_ready.
- Slot 0 update priority, highest first:
  - flush_i: slot 0 valid cleared.
  - stall_i: slot 0 holds.
  - md_hold: slot 0 holds.
  - accept: slot 0 loads the decoded word with valid=1, and illegal_o is registered from the illegal flag.
  - otherwise: slot 0 gets a bubble (valid=0, ctrl=0, illegal_o=0).
- Slots k>=1:
  - If stall_i: hold.
  - Else: take slot k-1 contents.
  - If slot 0 is under md_hold (and not stalled), slot 1 gets a bubble.
  - Final slot contents drop off the end.
- Flush:
  - Clears valid (and ctrl to 0) in slots 0..FLUSH_DEPTH-1 at the edge; has priority over stall and hold.
  - Also zeroes the md counter and illegal_o.
  - Slots >= FLUSH_DEPTH behave normally, including advancing if not stalled.
- Mul/div:
  - When MULDIV_EN and an accepted word is a mul/div op, the md counter loads MULDIV_CYCLES-1 on the same edge slot 0 loads.
  - Each edge without stall_i and without flush_i, the counter decrements.
  - The op leaves slot 0 on the first non-stalled edge after the counter reads 0, so it occupies slot 0 for exactly MULDIV_CYCLES unstalled cycles.
  - md_busy = md_hold.
  - The counter is $clog2(MULDIV_CYCLES) bits wide, with no wrap: it decrements only when non-zero.
- Timing: decode-to-slot-0 latency is 1 cycle; slot k is valid k+1 cycles after accept, absent stalls.
- Simultaneous events: flush with accept means the input is not taken (in_ready=0). Stall with a non-zero counter means the counter freezes.

Decomposition:
- rv32i_types additions: muldiv funct7 constant (7'b0000001); a packed typedef ctrl_slot_t (valid + rv32i_control_word); localparam-free decode helper function is_muldiv().
- Sub-module ctrl_decode: the purely combinational opcode-to-control-word case plus illegal flag.
- ctrl_pipe owns the slots, stall/flush priority and the md counter.

Test Plan:
1. Reset mid-stream: 3 accepted op_auipc, then rst_n=0 mid-cycle -> all slot_valid=0 and ctrl=0 immediately. After release, the first accept appears in slot 0 one edge later.
2. Streaming, no stall: op_auipc, op_load, op_store, op_br on consecutive cycles (STAGES=4) -> on cycle 4 slot_valid=4'b1111 with slot 3=auipc (aluop=alu_add) and slot 0=br.
3. Stall: stall_i high 3 cycles with slots full -> contents unchanged and in_ready=0. On release, one shift per edge.
4. Flush (FLUSH_DEPTH=2) with accept on the same cycle -> input dropped; slots 0,1 invalid next edge; slots 2,3 advance; md counter=0.
5. Mul/div (MULDIV_CYCLES=4): accept op_reg funct7=0000001 -> slot 0 holds 4 cycles with md_busy high for 3. Slot 1 gets bubbles; in_ready=0 until the op moves to slot 1. Repeat with MULDIV_EN=0 -> no hold.
6. Illegal: opcode 7'b1111111 accepted -> slot 0 valid=1, ctrl=0 except the opcode field, illegal_o=1 for exactly one cycle.

Source files
------------

// File: rtl/ctrl_pipe_pkg.sv
// Shared RV32I control-pipeline types: opcodes, ALU selects, control word and slot record.
package ctrl_pipe_pkg;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011
  } rv32i_opcode;

  // ALU select follows funct3 directly; alu_alt picks sub/sra.
  typedef enum logic [2:0] {
    alu_add  = 3'd0,
    alu_sll  = 3'd1,
    alu_slt  = 3'd2,
    alu_sltu = 3'd3,
    alu_xor  = 3'd4,
    alu_srl  = 3'd5,
    alu_or   = 3'd6,
    alu_and  = 3'd7
  } alu_ops;

  typedef enum logic [1:0] {
    rf_alu = 2'd0,
    rf_mem = 2'd1,
    rf_pc4 = 2'd2,
    rf_imm = 2'd3
  } regfilemux_sel_t;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef struct packed {
    rv32i_opcode     opcode;
    alu_ops          aluop;
    logic            alu_alt;
    logic            muldiv;
    logic            alumux1_pc;
    logic            alumux2_rs2;
    regfilemux_sel_t regfilemux_sel;
    logic            load_regfile;
    logic            mem_read;
    logic            mem_write;
    logic            is_branch;
    logic            is_jump;
    logic [2:0]      funct3;
  } rv32i_control_word;

  typedef struct packed {
    logic              valid;
    rv32i_control_word ctrl;
  } ctrl_slot_t;

  function automatic logic is_muldiv(input logic [6:0] opc, input logic [6:0] f7);
    return (opc == op_reg) && (f7 == FUNCT7_MULDIV);
  endfunction

endpackage

// File: rtl/ctrl_pipe_decode.sv
// Combinational opcode/funct decode into a control word plus an unknown-opcode flag.
module ctrl_decode
  import ctrl_pipe_pkg::*;
#(
  parameter int MULDIV_EN = 1
) (
  input  logic [6:0]        i_opcode,
  input  logic [2:0]        i_funct3,
  input  logic [6:0]        i_funct7,
  output rv32i_control_word o_word,
  output logic              o_illegal
);

  always_comb begin
    o_word        = '0;
    o_word.opcode = rv32i_opcode'(i_opcode);
    o_illegal     = 1'b0;
    case (i_opcode)
      op_lui: begin
        o_word.load_regfile   = 1'b1;
        o_word.regfilemux_sel = rf_imm;
      end
      op_auipc: begin
        o_word.alumux1_pc   = 1'b1;
        o_word.load_regfile = 1'b1;
      end
      op_jal: begin
        o_word.alumux1_pc     = 1'b1;
        o_word.load_regfile   = 1'b1;
        o_word.regfilemux_sel = rf_pc4;
        o_word.is_jump        = 1'b1;
      end
      op_jalr: begin
        o_word.load_regfile   = 1'b1;
        o_word.regfilemux_sel = rf_pc4;
        o_word.is_jump        = 1'b1;
      end
      op_br: begin
        o_word.alumux1_pc = 1'b1;
        o_word.is_branch  = 1'b1;
        o_word.funct3     = i_funct3;
      end
      op_load: begin
        o_word.mem_read       = 1'b1;
        o_word.load_regfile   = 1'b1;
        o_word.regfilemux_sel = rf_mem;
        o_word.funct3         = i_funct3;
      end
      op_store: begin
        o_word.mem_write = 1'b1;
        o_word.funct3    = i_funct3;
      end
      op_imm: begin
        o_word.aluop        = alu_ops'(i_funct3);
        o_word.alu_alt      = (i_funct3 == 3'b101) && i_funct7[5];
        o_word.load_regfile = 1'b1;
        o_word.funct3       = i_funct3;
      end
      op_reg: begin
        o_word.aluop        = alu_ops'(i_funct3);
        o_word.alu_alt      = i_funct7[5];
        o_word.alumux2_rs2  = 1'b1;
        o_word.load_regfile = 1'b1;
        o_word.funct3       = i_funct3;
        o_word.muldiv       = (MULDIV_EN != 0) && is_muldiv(i_opcode, i_funct7);
      end
      // Unknown opcodes keep only the raw opcode field so the trap handler can see it.
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Control-word pipeline: decoded words ride STAGES valid-tagged slots with stall, partial flush and mul/div hold.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int STAGES        = 4,
  parameter int FLUSH_DEPTH   = 2,
  parameter int MULDIV_EN     = 1,
  parameter int MULDIV_CYCLES = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [6:0]                     opcode,
  input  logic [2:0]                     funct3,
  input  logic [6:0]                     funct7,
  input  logic                           stall_i,
  input  logic                           flush_i,
  output rv32i_control_word [STAGES-1:0] slot_ctrl,
  output logic [STAGES-1:0]              slot_valid,
  output logic                           illegal_o,
  output logic                           md_busy
);

  localparam int               CNT_W   = $clog2(MULDIV_CYCLES);
  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MULDIV_CYCLES - 1);

  ctrl_slot_t [STAGES-1:0] r_slot;
  ctrl_slot_t [STAGES-1:0] w_slot_next;
  ctrl_slot_t              w_slot0_next;
  logic                    r_illegal;
  logic                    w_illegal_next;
  logic [CNT_W-1:0]        r_md_cnt;
  logic [CNT_W-1:0]        w_md_cnt_next;
  rv32i_control_word       w_word;
  logic                    w_illegal;
  logic                    w_md_hold;
  logic                    w_accept;

  ctrl_decode #(
    .MULDIV_EN(MULDIV_EN)
  ) u_decode (
    .i_opcode (opcode),
    .i_funct3 (funct3),
    .i_funct7 (funct7),
    .o_word   (w_word),
    .o_illegal(w_illegal)
  );

  assign w_md_hold = (r_md_cnt != '0);
  assign in_ready  = !stall_i && !w_md_hold && !flush_i;
  assign w_accept  = in_valid && in_ready;

  always_comb begin
    w_slot0_next   = r_slot[0];
    w_illegal_next = r_illegal;
    if (flush_i) begin
      w_slot0_next   = '0;
      w_illegal_next = 1'b0;
    end else if (stall_i || w_md_hold) begin
      w_slot0_next   = r_slot[0];
      w_illegal_next = r_illegal;
    end else if (w_accept) begin
      w_slot0_next.valid = 1'b1;
      w_slot0_next.ctrl  = w_word;
      w_illegal_next     = w_illegal;
    end else begin
      w_slot0_next   = '0;
      w_illegal_next = 1'b0;
    end
  end

  // Accept and a non-zero count are mutually exclusive, so load and decrement never collide.
  always_comb begin
    w_md_cnt_next = r_md_cnt;
    if (flush_i) begin
      w_md_cnt_next = '0;
    end else if (!stall_i) begin
      if (w_accept && w_word.muldiv) begin
        w_md_cnt_next = MD_LOAD;
      end else if (r_md_cnt != '0) begin
        w_md_cnt_next = r_md_cnt - 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_slot
      if (gi == 0) begin : g_head
        assign w_slot_next[gi] = w_slot0_next;
      end else begin : g_tail
        localparam bit IN_FLUSH = (gi < FLUSH_DEPTH);
        localparam bit IS_FIRST = (gi == 1);
        assign w_slot_next[gi] = (flush_i && IN_FLUSH)    ? '0 :
                                 stall_i                  ? r_slot[gi] :
                                 (IS_FIRST && w_md_hold)  ? '0 :
                                                            r_slot[gi-1];
      end
      assign slot_ctrl[gi]  = r_slot[gi].ctrl;
      assign slot_valid[gi] = r_slot[gi].valid;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot    <= '0;
      r_illegal <= 1'b0;
      r_md_cnt  <= '0;
    end else begin
      r_slot    <= w_slot_next;
      r_illegal <= w_illegal_next;
      r_md_cnt  <= w_md_cnt_next;
    end
  end

  assign illegal_o = r_illegal;
  assign md_busy   = w_md_hold;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: two instances (mul/div hold on and off) checked against a slot-source model every cycle.
module tb_ctrl_pipe;
  import ctrl_pipe_pkg::*;

  localparam int ST = 4;
  localparam int FD = 2;
  localparam int MC = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       stall_i;
  logic       flush_i;

  logic                       in_ready, in_ready_nm;
  rv32i_control_word [ST-1:0] slot_ctrl, slot_ctrl_nm;
  logic [ST-1:0]              slot_valid, slot_valid_nm;
  logic                       illegal_o, illegal_nm;
  logic                       md_busy, md_busy_nm;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  ctrl_pipe #(.STAGES(ST), .FLUSH_DEPTH(FD), .MULDIV_EN(1), .MULDIV_CYCLES(MC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .stall_i(stall_i), .flush_i(flush_i),
    .slot_ctrl(slot_ctrl), .slot_valid(slot_valid),
    .illegal_o(illegal_o), .md_busy(md_busy));

  ctrl_pipe #(.STAGES(ST), .FLUSH_DEPTH(FD), .MULDIV_EN(0), .MULDIV_CYCLES(MC)) dut_nm (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_nm),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .stall_i(stall_i), .flush_i(flush_i),
    .slot_ctrl(slot_ctrl_nm), .slot_valid(slot_valid_nm),
    .illegal_o(illegal_nm), .md_busy(md_busy_nm));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  bit                m_v   [2][ST];
  rv32i_control_word m_w   [2][ST];
  bit                m_ill [2];
  int                m_cnt [2];

  function automatic rv32i_control_word m_decode(input logic [6:0] op, input logic [2:0] f3,
                                                 input logic [6:0] f7, input bit mden);
    rv32i_control_word w;
    w = '0;
    w.opcode = rv32i_opcode'(op);
    case (op)
      7'b0110111: begin w.load_regfile = 1; w.regfilemux_sel = rf_imm; end
      7'b0010111: begin w.alumux1_pc = 1; w.load_regfile = 1; end
      7'b1101111: begin w.alumux1_pc = 1; w.load_regfile = 1; w.regfilemux_sel = rf_pc4; w.is_jump = 1; end
      7'b1100111: begin w.load_regfile = 1; w.regfilemux_sel = rf_pc4; w.is_jump = 1; end
      7'b1100011: begin w.alumux1_pc = 1; w.is_branch = 1; w.funct3 = f3; end
      7'b0000011: begin w.mem_read = 1; w.load_regfile = 1; w.regfilemux_sel = rf_mem; w.funct3 = f3; end
      7'b0100011: begin w.mem_write = 1; w.funct3 = f3; end
      7'b0010011: begin
        w.aluop = alu_ops'(f3); w.alu_alt = (f3 == 3'b101) && f7[5];
        w.load_regfile = 1; w.funct3 = f3;
      end
      7'b0110011: begin
        w.aluop = alu_ops'(f3); w.alu_alt = f7[5]; w.alumux2_rs2 = 1;
        w.load_regfile = 1; w.funct3 = f3; w.muldiv = mden && (f7 == 7'b0000001);
      end
      default: ;
    endcase
    return w;
  endfunction

  function automatic bit m_known(input logic [6:0] op);
    return op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                      7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
  endfunction

  function automatic bit m_ready(input int d);
    return !stall_i && !flush_i && (m_cnt[d] == 0);
  endfunction

  function automatic bit m_acc(input int d);
    return in_valid && m_ready(d);
  endfunction

  // Where slot k's next content comes from: -1 empty, -2 the new instruction, else a slot index.
  function automatic int src_of(input int d, input int k);
    if (flush_i && k < FD) return -1;
    if (k == 0) begin
      if (stall_i || m_cnt[d] != 0) return 0;
      if (m_acc(d)) return -2;
      return -1;
    end
    if (stall_i) return k;
    if (k == 1 && m_cnt[d] != 0) return -1;
    return k - 1;
  endfunction

  function automatic bit next_v(input int d, input int k);
    int s;
    s = src_of(d, k);
    if (s == -1) return 1'b0;
    if (s == -2) return 1'b1;
    return m_v[d][s];
  endfunction

  function automatic rv32i_control_word next_w(input int d, input int k);
    int s;
    s = src_of(d, k);
    if (s == -1) return '0;
    if (s == -2) return m_decode(opcode, funct3, funct7, d == 0);
    return m_w[d][s];
  endfunction

  function automatic bit next_ill(input int d);
    int s;
    s = src_of(d, 0);
    if (s == 0) return m_ill[d];
    if (s == -2) return !m_known(opcode);
    return 1'b0;
  endfunction

  function automatic int next_cnt(input int d);
    rv32i_control_word w;
    w = m_decode(opcode, funct3, funct7, d == 0);
    if (flush_i) return 0;
    if (stall_i) return m_cnt[d];
    if (m_acc(d) && w.muldiv) return MC - 1;
    return (m_cnt[d] > 0) ? m_cnt[d] - 1 : 0;
  endfunction

  function automatic logic [ST-1:0] exp_valid(input int d);
    logic [ST-1:0] v;
    for (int k = 0; k < ST; k++) v[k] = m_v[d][k];
    return v;
  endfunction

  function automatic logic [ST*$bits(rv32i_control_word)-1:0] exp_ctrl(input int d);
    rv32i_control_word [ST-1:0] e;
    for (int k = 0; k < ST; k++) e[k] = m_w[d][k];
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < ST; k++) begin
          m_v[d][k] <= 1'b0;
          m_w[d][k] <= '0;
        end
        m_ill[d] <= 1'b0;
        m_cnt[d] <= 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < ST; k++) begin
          m_v[d][k] <= next_v(d, k);
          m_w[d][k] <= next_w(d, k);
        end
        m_ill[d] <= next_ill(d);
        m_cnt[d] <= next_cnt(d);
      end
    end
  end

  // Continuous comparison on the falling edge, away from the active edge.
  always @(negedge clk) begin
    chk("md.slot_valid", slot_valid, exp_valid(0));
    chk("md.slot_ctrl", slot_ctrl, exp_ctrl(0));
    chk("md.illegal_o", illegal_o, m_ill[0]);
    chk("md.md_busy", md_busy, m_cnt[0] != 0);
    chk("md.in_ready", in_ready, m_ready(0));
    chk("nm.slot_valid", slot_valid_nm, exp_valid(1));
    chk("nm.slot_ctrl", slot_ctrl_nm, exp_ctrl(1));
    chk("nm.illegal_o", illegal_nm, m_ill[1]);
    chk("nm.md_busy", md_busy_nm, m_cnt[1] != 0);
    chk("nm.in_ready", in_ready_nm, m_ready(1));
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input bit v, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input bit st, input bit fl);
    in_valid = v; opcode = op; funct3 = f3; funct7 = f7; stall_i = st; flush_i = fl;
    $display("cycle t=%0t v=%0b op=%b f3=%0d f7=%b stall=%0b flush=%0b", $time, v, op, f3, f7, st, fl);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 7'h00, 3'd0, 7'd0, 0, 0);
  endtask

  rv32i_control_word ill_word;
  int busy_cycles;

  initial begin
    rst_n = 1'b0; in_valid = 0; opcode = '0; funct3 = '0; funct7 = '0; stall_i = 0; flush_i = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset.slot_valid", slot_valid, 4'b0000);
    chk("reset.md_busy", md_busy, 1'b0);
    rst_n = 1'b1;

    // Reset mid-stream
    repeat (3) step(1, op_auipc, 3'd0, 7'd0, 0, 0);
    chk("t1.fill_valid", slot_valid, 4'b0111);
    #1 rst_n = 1'b0;
    #1;
    chk("t1.async_valid", slot_valid, 4'b0000);
    chk("t1.async_ctrl", slot_ctrl, 96'h0);
    chk("t1.async_illegal", illegal_o, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(1, op_auipc, 3'd0, 7'd0, 0, 0);
    chk("t1.first_valid", slot_valid, 4'b0001);
    chk("t1.first_op", slot_ctrl[0].opcode, op_auipc);

    // Streaming
    idle(4);
    step(1, op_auipc, 3'd0, 7'd0, 0, 0);
    step(1, op_load,  3'd2, 7'd0, 0, 0);
    step(1, op_store, 3'd2, 7'd0, 0, 0);
    step(1, op_br,    3'd1, 7'd0, 0, 0);
    chk("t2.valid", slot_valid, 4'b1111);
    chk("t2.s3_op", slot_ctrl[3].opcode, op_auipc);
    chk("t2.s3_aluop", slot_ctrl[3].aluop, alu_add);
    chk("t2.s0_op", slot_ctrl[0].opcode, op_br);
    chk("t2.s2_memrd", slot_ctrl[2].mem_read, 1'b1);

    // Stall with full slots
    repeat (3) step(1, op_imm, 3'd0, 7'd0, 1, 0);
    chk("t3.valid", slot_valid, 4'b1111);
    chk("t3.s3_op", slot_ctrl[3].opcode, op_auipc);
    chk("t3.s0_op", slot_ctrl[0].opcode, op_br);
    chk("t3.in_ready", in_ready, 1'b0);
    idle(1);
    chk("t3.shift_valid", slot_valid, 4'b1110);
    chk("t3.shift_s3", slot_ctrl[3].opcode, op_load);

    // Flush with a simultaneous input
    step(1, op_auipc, 3'd0, 7'd0, 0, 0);
    step(1, op_load,  3'd0, 7'd0, 0, 0);
    step(1, op_store, 3'd0, 7'd0, 0, 0);
    step(1, op_br,    3'd0, 7'd0, 0, 0);
    step(1, op_imm,   3'd4, 7'd0, 0, 1);
    chk("t4.in_ready", in_ready, 1'b0);
    chk("t4.valid", slot_valid, 4'b1100);
    chk("t4.s3_op", slot_ctrl[3].opcode, op_load);
    chk("t4.s2_op", slot_ctrl[2].opcode, op_store);
    chk("t4.s0_ctrl", slot_ctrl[0], 24'h0);
    chk("t4.md_busy", md_busy, 1'b0);

    // Mul/div hold
    idle(4);
    step(1, op_reg, 3'd0, 7'b0000001, 0, 0);
    busy_cycles = md_busy ? 1 : 0;
    chk("t5.busy_start", md_busy, 1'b1);
    chk("t5.muldiv_bit", slot_ctrl[0].muldiv, 1'b1);
    chk("t5.nm_busy", md_busy_nm, 1'b0);
    chk("t5.nm_muldiv_bit", slot_ctrl_nm[0].muldiv, 1'b0);
    chk("t5.in_ready_hold", in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1, op_imm, 3'd0, 7'd0, 0, 0);
      if (md_busy) busy_cycles++;
    end
    chk("t5.busy_cycles", busy_cycles, 3);
    chk("t5.still_s0", slot_ctrl[0].opcode, op_reg);
    chk("t5.bubbles", slot_valid, 4'b0001);
    chk("t5.ready_again", in_ready, 1'b1);
    step(1, op_imm, 3'd0, 7'd0, 0, 0);
    chk("t5.moved_s1", slot_ctrl[1].opcode, op_reg);
    chk("t5.new_s0", slot_ctrl[0].opcode, op_imm);
    chk("t5.moved_valid", slot_valid, 4'b0011);

    // Stall freezes the hold; flush cancels it
    step(1, op_reg, 3'd4, 7'b0000001, 0, 0);
    step(1, op_imm, 3'd0, 7'd0, 1, 0);
    step(1, op_imm, 3'd0, 7'd0, 1, 0);
    step(1, op_imm, 3'd0, 7'd0, 0, 0);
    chk("t5.busy_after_stall", md_busy, 1'b1);
    step(0, op_imm, 3'd0, 7'd0, 0, 1);
    chk("t5.flush_busy", md_busy, 1'b0);
    chk("t5.flush_valid01", slot_valid[1:0], 2'b00);
    idle(1);

    // Illegal opcode
    idle(4);
    step(1, 7'b1111111, 3'd0, 7'd0, 0, 0);
    ill_word = '0;
    ill_word.opcode = rv32i_opcode'(7'b1111111);
    chk("t6.illegal", illegal_o, 1'b1);
    chk("t6.valid", slot_valid, 4'b0001);
    chk("t6.ctrl", slot_ctrl[0], ill_word);
    idle(1);
    chk("t6.illegal_one_cycle", illegal_o, 1'b0);
    idle(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

endmodule
